// File: rtl/qracc_pkg.sv
// Shared types and default timing for the QRAcc SRAM controller.
// Holds the controller state encoding and a couple of elaboration-time helpers.
package qracc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PCH,
    S_WL,
    S_SENSE,
    S_RESP
  } sram_ctrl_state_t;

  localparam int SRAM_PCH_CYCLES = 1;
  localparam int SRAM_WL_CYCLES  = 2;
  localparam int SRAM_SA_CYCLES  = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Address width that stays >= 1 even for a single-row macro.
  function automatic int addr_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/qracc_row_decoder.sv
// Combinational row-address to one-hot wordline decoder with enable.
// Addresses beyond numRows (non-power-of-two macros) decode to all zeros.
module qracc_row_decoder
  import qracc_pkg::*;
#(
  parameter int numRows = 128,
  parameter int AW      = addr_width(numRows)
) (
  input  logic [AW-1:0]      addr_i,
  input  logic               en_i,
  output logic [numRows-1:0] wl_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    wl_o = '0;
    for (int i = 0; i < numRows; i++) begin
      if (en_i && (addr_i == AW'(i))) wl_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/qracc_sram_ctrl.sv
// Responder end of the QRAcc SRAM request interface: sequences PCH/WL/SAEN for one word access.
// Optional write read-back check enabled by defining QRACC_SRAM_WRITE_VERIFY_EN (adds wr_err_o).
module qracc_sram_ctrl
  import qracc_pkg::*;
#(
  parameter int numRows   = 128,
  parameter int numCols   = 32,
  parameter int pchCycles = SRAM_PCH_CYCLES,
  parameter int wlCycles  = SRAM_WL_CYCLES,
  parameter int saCycles  = SRAM_SA_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rq_wr_i,
  input  logic                       rq_valid_i,
  output logic                       rq_ready_o,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  input  logic [numCols-1:0]         wr_data_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  input  logic [numCols-1:0]         sa_out_i,
  output logic [numRows-1:0]         wl_o,
  output logic                       pch_o,
  output logic                       write_o,
  output logic [numCols-1:0]         wr_data_o,
  output logic [numCols-1:0]         csel_o,
  output logic                       saen_o
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
  ,
  output logic                       wr_err_o
`endif
);

  localparam int AW = $clog2(numRows);
  localparam int CW = $clog2(max3(pchCycles, wlCycles, saCycles)) + 1;

  sram_ctrl_state_t state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               wr_q, wr_d;
  logic               vfy_q, vfy_d;
  logic [numCols-1:0] wdata_q, wdata_d;
  logic [numCols-1:0] rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  logic [numRows-1:0] wl_q, wl_d;
  logic               pch_q, pch_d;
  logic               write_q, write_d;
  logic [numCols-1:0] wr_data_q, wr_data_d;
  logic [numCols-1:0] csel_q, csel_d;
  logic               saen_q, saen_d;
  logic               wl_en;

`ifdef QRACC_SRAM_WRITE_VERIFY_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    addr_d    = addr_q;
    wr_d      = wr_q;
    vfy_d     = vfy_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rq_valid_i) begin
          addr_d  = addr_i;
          wr_d    = rq_wr_i;
          wdata_d = wr_data_i;
          vfy_d   = 1'b0;
          state_d = S_PCH;
        end
      end
      S_PCH: begin
        if (cnt_q == CW'(pchCycles - 1)) begin
          cnt_d   = '0;
          state_d = S_WL;
        end
      end
      S_WL: begin
        if (cnt_q == CW'(wlCycles - 1)) begin
          cnt_d = '0;
          if (wr_q && !vfy_q) begin
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
            vfy_d   = 1'b1;
            state_d = S_PCH;
`else
            state_d = S_IDLE;
`endif
          end else begin
            state_d = S_SENSE;
          end
        end
      end
      S_SENSE: begin
        if (cnt_q == CW'(saCycles - 1)) begin
          cnt_d   = '0;
          state_d = S_RESP;
          // Verify reads only compare; they never disturb the read-data holding register.
          if (vfy_q) begin
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
            err_d = (sa_out_i != wdata_q);
`endif
          end else begin
            rd_data_d = sa_out_i;
          end
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Analog pins are decoded from the next state and registered, so they change only on clk.
  assign wl_en      = (state_d == S_WL) || (state_d == S_SENSE);
  assign pch_d      = (state_d == S_PCH);
  assign write_d    = (state_d == S_WL) && wr_d && !vfy_d;
  assign wr_data_d  = write_d ? wdata_d : '0;
  assign csel_d     = {numCols{state_d == S_WL}};
  assign saen_d     = (state_d == S_SENSE);
  assign rd_valid_d = (state_d == S_RESP) && !vfy_d;

  qracc_row_decoder #(
    .numRows (numRows),
    .AW      (AW)
  ) u_row_decoder (
    .addr_i (addr_d),
    .en_i   (wl_en),
    .wl_o   (wl_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      vfy_q      <= 1'b0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wl_q       <= '0;
      pch_q      <= 1'b0;
      write_q    <= 1'b0;
      wr_data_q  <= '0;
      csel_q     <= '0;
      saen_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      vfy_q      <= vfy_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wl_q       <= wl_d;
      pch_q      <= pch_d;
      write_q    <= write_d;
      wr_data_q  <= wr_data_d;
      csel_q     <= csel_d;
      saen_q     <= saen_d;
    end
  end

`ifdef QRACC_SRAM_WRITE_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign wr_err_o = err_q;
`endif

  assign rq_ready_o = (state_q == S_IDLE);
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign wl_o       = wl_q;
  assign pch_o      = pch_q;
  assign write_o    = write_q;
  assign wr_data_o  = wr_data_q;
  assign csel_o     = csel_q;
  assign saen_o     = saen_q;

endmodule

// File: tb/tb_qracc_sram_ctrl.sv
// Directed bench for qracc_sram_ctrl: table of single requests plus hand-written multi-cycle sequences.
// Read-back checks are included when QRACC_SRAM_WRITE_VERIFY_EN is defined.
module tb_qracc_sram_ctrl;

  localparam int P = 1;
  localparam int W = 2;
  localparam int S = 1;
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         rq_wr_i, rq_valid_i, rq_ready_o, rd_valid_o;
  logic [31:0]  rd_data_o, wr_data_i, sa_out_i, wr_data_o, csel_o;
  logic [6:0]   addr_i;
  logic [127:0] wl_o;
  logic         pch_o, write_o, saen_o;
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
  logic         wr_err_o;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_rd = '0;

  always #5 clk = ~clk;

  qracc_sram_ctrl #(
    .numRows(128), .numCols(32), .pchCycles(P), .wlCycles(W), .saCycles(S)
  ) dut (
    .clk(clk), .rst(rst), .rq_wr_i(rq_wr_i), .rq_valid_i(rq_valid_i),
    .rq_ready_o(rq_ready_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .wr_data_i(wr_data_i), .addr_i(addr_i), .sa_out_i(sa_out_i), .wl_o(wl_o),
    .pch_o(pch_o), .write_o(write_o), .wr_data_o(wr_data_o), .csel_o(csel_o),
    .saen_o(saen_o)
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
    , .wr_err_o(wr_err_o)
`endif
  );

  typedef struct {
    logic         wr;
    logic [6:0]   addr;
    logic [31:0]  wdata;
    logic [31:0]  sa;
    logic [127:0] exp_wl;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One request from acceptance to the first idle cycle, checking every pin every cycle.
  task automatic run_op(input vec_t v);
    int total, rb;
    logic in_pch, in_wl, wdrv, in_sense, in_resp;
    next_cycle();
    rq_valid_i = 1'b1; rq_wr_i = v.wr; addr_i = v.addr; wr_data_i = v.wdata;
    @(negedge clk);
    check("accept_ready", rq_ready_o, 1'b1);
    next_cycle();
    rq_valid_i = 1'b0;
    wr_data_i  = ~v.wdata;
    addr_i     = v.addr ^ 7'h55;
    rb    = v.wr ? P + W : 0;
    total = (!v.wr || VFY) ? rb + P + W + S + 2 : P + W + 1;
    for (int c = 1; c <= total; c++) begin
      sa_out_i = saen_o ? v.sa : 32'h1234_5678;
      in_pch = 1'b0; in_wl = 1'b0; wdrv = 1'b0; in_sense = 1'b0; in_resp = 1'b0;
      if (v.wr) begin
        if (c <= P) in_pch = 1'b1;
        else if (c <= P + W) begin in_wl = 1'b1; wdrv = 1'b1; end
      end
      if (!v.wr || VFY) begin
        if (c > rb && c <= rb + P) in_pch = 1'b1;
        else if (c > rb + P && c <= rb + P + W) in_wl = 1'b1;
        else if (c > rb + P + W && c <= rb + P + W + S) in_sense = 1'b1;
        else if (c == rb + P + W + S + 1) in_resp = 1'b1;
      end
      if (in_resp && !v.wr) exp_rd = v.sa;
      @(negedge clk);
      check($sformatf("pch c%0d", c),      pch_o,     in_pch);
      check($sformatf("wl c%0d", c),       wl_o,      (in_wl || in_sense) ? v.exp_wl : 128'd0);
      check($sformatf("write c%0d", c),    write_o,   wdrv);
      check($sformatf("wr_data c%0d", c),  wr_data_o, wdrv ? v.wdata : 32'd0);
      check($sformatf("csel c%0d", c),     csel_o,    in_wl ? 32'hFFFF_FFFF : 32'd0);
      check($sformatf("saen c%0d", c),     saen_o,    in_sense);
      check($sformatf("rd_valid c%0d", c), rd_valid_o, in_resp && !v.wr);
      check($sformatf("ready c%0d", c),    rq_ready_o, c == total);
      if (in_resp || c == total) check($sformatf("rd_data c%0d", c), rd_data_o, exp_rd);
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
      check($sformatf("wr_err c%0d", c), wr_err_o, 1'b0);
`endif
      if (c < total) next_cycle();
    end
  endtask

  vec_t vecs[6];
  int acc, pulses, pch_cnt, write_seen, errs, acc_cyc[3];
  logic saw0, saw127;

  initial begin
    vecs[0] = '{1'b1, 7'd5,   32'hDEAD_BEEF, 32'hDEAD_BEEF, 128'h20};
    vecs[1] = '{1'b0, 7'd5,   32'h0000_0000, 32'hDEAD_BEEF, 128'h20};
    vecs[2] = '{1'b1, 7'd0,   32'h0000_0001, 32'h0000_0001, 128'h1};
    vecs[3] = '{1'b0, 7'd127, 32'h0000_0000, 32'h8000_0000, 128'h8000_0000_0000_0000_0000_0000_0000_0000};
    vecs[4] = '{1'b1, 7'd127, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 128'h8000_0000_0000_0000_0000_0000_0000_0000};
    vecs[5] = '{1'b0, 7'd64,  32'h0000_0000, 32'h0F0F_3C3C, 128'h1_0000_0000_0000_0000};

    rst = 1'b1; rq_wr_i = 1'b0; rq_valid_i = 1'b0; wr_data_i = '0; addr_i = '0; sa_out_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst ready",    rq_ready_o, 1'b1);
    check("rst rd_valid", rd_valid_o, 1'b0);
    check("rst rd_data",  rd_data_o,  32'd0);
    check("rst wl",       wl_o,       128'd0);
    check("rst pch",      pch_o,      1'b0);
    check("rst write",    write_o,    1'b0);
    check("rst csel",     csel_o,     32'd0);
    check("rst saen",     saen_o,     1'b0);

    foreach (vecs[i]) run_op(vecs[i]);

    // Back-to-back reads with valid held: addr 0 then 127.
    next_cycle();
    acc = 0; pulses = 0; saw0 = 1'b0; saw127 = 1'b0;
    sa_out_i = 32'hCAFE_0000;
    rq_valid_i = 1'b1; rq_wr_i = 1'b0; addr_i = 7'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (rq_valid_i && rq_ready_o) begin acc_cyc[acc] = i; acc++; end
      if (rd_valid_o) pulses++;
      if (wl_o == 128'd1) saw0 = 1'b1;
      if (wl_o == (128'd1 << 127)) saw127 = 1'b1;
      next_cycle();
      if (acc == 1) addr_i = 7'd127;
      if (acc >= 2) rq_valid_i = 1'b0;
      if (acc > 2) break;
    end
    rq_valid_i = 1'b0;
    check("b2b accepts", acc, 2);
    check("b2b gap", acc_cyc[1] - acc_cyc[0], P + W + S + 2);
    check("b2b pulses", pulses, 2);
    check("b2b wl row0", saw0, 1'b1);
    check("b2b wl row127", saw127, 1'b1);
    check("b2b rd_data", rd_data_o, 32'hCAFE_0000);

    // Busy request pulsed in cycle 2 of a read must be dropped.
    next_cycle();
    pulses = 0; pch_cnt = 0; write_seen = 0;
    sa_out_i = 32'h5555_AAAA;
    rq_valid_i = 1'b1; rq_wr_i = 1'b0; addr_i = 7'd9;
    next_cycle();
    rq_valid_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin rq_valid_i = 1'b1; rq_wr_i = 1'b1; addr_i = 7'd20; wr_data_i = 32'h1111_2222; end
      if (c == 3) rq_valid_i = 1'b0;
      @(negedge clk);
      if (pch_o) pch_cnt++;
      if (rd_valid_o) pulses++;
      if (write_o) write_seen++;
      if (c == 2) check("busy ready", rq_ready_o, 1'b0);
      if (c == 3) check("busy wl addr", wl_o, 128'd1 << 9);
      next_cycle();
    end
    check("busy pch count", pch_cnt, 1);
    check("busy rd pulses", pulses, 1);
    check("busy no write", write_seen, 0);
    check("busy rd_data", rd_data_o, 32'h5555_AAAA);

`ifdef QRACC_SRAM_WRITE_VERIFY_EN
    for (int k = 0; k < 2; k++) begin
      errs = 0; pulses = 0;
      rq_valid_i = 1'b1; rq_wr_i = 1'b1; addr_i = 7'd7; wr_data_i = 32'hA5A5_A5A5;
      next_cycle();
      rq_valid_i = 1'b0;
      for (int c = 1; c <= 12; c++) begin
        sa_out_i = saen_o ? ((k == 0) ? 32'hA5A5_A5A4 : 32'hA5A5_A5A5) : 32'h0;
        @(negedge clk);
        if (wr_err_o) errs++;
        if (rd_valid_o) pulses++;
        if (c == 2 * P + 2 * W + S + 2) check($sformatf("vfy ready k%0d", k), rq_ready_o, 1'b1);
        next_cycle();
      end
      check($sformatf("vfy err count k%0d", k), errs, (k == 0) ? 1 : 0);
      check($sformatf("vfy rd_valid k%0d", k), pulses, 0);
      check($sformatf("vfy rd_data k%0d", k), rd_data_o, 32'h5555_AAAA);
    end
`endif

    // Asynchronous reset during WL of a write to row 3.
    next_cycle();
    rq_valid_i = 1'b1; rq_wr_i = 1'b1; addr_i = 7'd3; wr_data_i = 32'h0BAD_F00D;
    next_cycle();
    rq_valid_i = 1'b0;
    next_cycle();
    @(negedge clk);
    check("mid wl before rst", wl_o, 128'd1 << 3);
    #2 rst = 1'b1;
    #1;
    check("mid rst wl",    wl_o,    128'd0);
    check("mid rst write", write_o, 1'b0);
    check("mid rst pch",   pch_o,   1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("post rst ready",   rq_ready_o, 1'b1);
    check("post rst rd_data", rd_data_o,  32'd0);
    next_cycle();
    @(negedge clk);
    check("post rst idle pch", pch_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/qracc_sram_ctrl.md
Name: qracc_sram_ctrl

Overview:
- Responder (slave) end of the QRAcc SRAM request interface.
- Accepts word read/write requests via the `rq_*` valid/ready handshake.
- Sequences the analog SRAM control pins (PCH, WL, WRITE, WR_DATA, CSEL, SAEN) through precharge, wordline and sense phases.
- Captures SA_OUT and returns read data with a one-cycle `rd_valid_o` pulse; sits between the digital weight loader and the analog macro.

Parameters:
- numRows, 128, number of wordlines/rows in the macro.
- numCols, 32, word width / number of bitline columns.
- pchCycles, 1, precharge phase length in cycles (>=1).
- wlCycles, 2, wordline-active phase length in cycles (>=1).
- saCycles, 1, sense-amp enable phase length in cycles (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rq_wr_i  in  1  1=write, 0=read.
- rq_valid_i  in  1  request valid.
- rq_ready_o  out  1  request accepted when rq_valid_i && rq_ready_o.
- rd_valid_o  out  1  one-cycle pulse, rd_data_o valid.
- rd_data_o  out  numCols  read data, held until next read completes.
- wr_data_i  in  numCols  write data.
- addr_i  in  $clog2(numRows)  row address.
- sa_out_i  in  numCols  sense-amp outputs (SA_OUT).
- wl_o  out  numRows  one-hot wordline (WL).
- pch_o  out  1  bitline precharge (PCH).
- write_o  out  1  write driver enable (WRITE).
- wr_data_o  out  numCols  write driver data (WR_DATA).
- csel_o  out  numCols  column select (CSEL).
- saen_o  out  1  sense-amp enable (SAEN).

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- On rst, immediately and regardless of state:
  - state=IDLE; rd_valid_o=0; rd_data_o=0.
  - wl_o, pch_o, write_o, wr_data_o, csel_o, saen_o all 0.
  - rq_ready_o=1 after release.
- FSM states: IDLE, PCH, WL, SENSE, RESP.
- IDLE:
  - rq_ready_o=1.
  - On valid&&ready, latch addr, wr flag and data; go to PCH.
  - rq_ready_o=0 in every other state; requests there are ignored (not queued).
- PCH: pch_o=1 for pchCycles cycles, then WL.
- WL:
  - wl_o=onehot(addr latch) for wlCycles cycles.
  - Write: write_o=1, wr_data_o=latched data, csel_o=all ones; then IDLE.
  - Read: write_o=0, wr_data_o=0, csel_o=all ones; then SENSE.
- SENSE:
  - wl_o held and saen_o=1 for saCycles cycles.
  - sa_out_i is sampled into rd_data_o on the last SENSE cycle's edge; then RESP.
- RESP: rd_valid_o=1 for exactly that cycle; rq_ready_o=0; next state IDLE.
- Latency (acceptance edge = cycle 0):
  - Write: ready again at cycle P+W+1.
  - Read: rd_valid_o in cycle P+W+S+1, ready again in cycle P+W+S+2.
- Address >= numRows (non-power-of-two numRows only): request still runs all phases; wl_o stays 0; a read returns sa_out_i as sampled.
- All analog outputs are registered (glitch-free); wl_o is never asserted while pch_o=1.
- Phase counter width is $clog2(max(pchCycles,wlCycles,saCycles))+1; it resets to 0 on every state entry.
- rq_valid_i deasserting after acceptance has no effect.

Optional Feature:
- Macro: QRACC_SRAM_WRITE_VERIFY_EN.
- When defined:
  - Each write is followed automatically by a PCH/WL/SENSE read-back of the same row.
  - Adds output wr_err_o (1 bit). In the cycle after sensing, it pulses high for one cycle if the sensed word != the written word.
  - rd_valid_o is not pulsed for verify reads, and rd_data_o is not updated.
  - Write latency becomes 2P+2W+S+2 cycles.
- When undefined: no wr_err_o port; writes end after WL as described.

Decomposition:
- qracc_pkg gains:
  - typedef enum logic [2:0] sram_ctrl_state_t {S_IDLE, S_PCH, S_WL, S_SENSE, S_RESP};
  - default timing constants SRAM_PCH_CYCLES=1, SRAM_WL_CYCLES=2, SRAM_SA_CYCLES=1.
- One sub-module, qracc_row_decoder: combinational address-to-one-hot with enable, zero output when addr >= numRows.
- The FSM, registers and outputs stay in qracc_sram_ctrl.

Test Plan:
- Reset mid-operation: rst asserted during WL of a write to row 3 -> within the same cycle wl_o=0, write_o=0, pch_o=0; after release rq_ready_o=1 and rd_data_o=0.
- Write addr=5, data=0xDEADBEEF: accept at cycle 0 ->
  - pch_o=1 in cycle 1;
  - wl_o=0x20 with write_o=1 and wr_data_o=0xDEADBEEF in cycles 2-3;
  - rq_ready_o=1 in cycle 4.
- Read addr=5, bench drives sa_out_i=0xDEADBEEF while saen_o=1 -> saen_o=1 in cycle 4; rd_valid_o pulses in cycle 5 with rd_data_o=0xDEADBEEF, which is held after the pulse.
- Back-to-back: rq_valid_i held high with reads to addr 0 then 127 -> second accepted only when rq_ready_o returns; wl_o=bit127 in the second op's WL phase; exactly two rd_valid_o pulses.
- Requests ignored when busy: rq_valid_i pulsed in cycle 2 of a read, with a different addr -> not accepted; no extra operation; latched addr unchanged.
- With QRACC_SRAM_WRITE_VERIFY_EN: write 0xA5A5A5A5 with sa_out_i forced to 0xA5A5A5A4 during sense -> wr_err_o pulses once; rd_valid_o stays 0. Repeat with matching data -> wr_err_o stays 0.
